uart_resp_framer: RTL and testbench



---
 rtl/uart_resp_framer_if.sv | 27 ++
 rtl/uart_resp_framer.sv | 207 ++++++++++++++++++++
 tb/tb_uart_resp_framer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_resp_framer_if.sv
// Signal bundle linking the command path, the response framer and the byte transmitter.
interface uart_resp_framer_if #(
    parameter int NUM_CHANNELS = 3
);
    logic                    resp_req;
    logic [7:0]              resp_func;
    logic [7:0]              resp_ch;
    logic [NUM_CHANNELS-1:0] pwm_busy;
    logic [NUM_CHANNELS-1:0] pwm_valid;
    logic                    tx_busy;
    logic                    tx_en;
    logic [7:0]              tx_data;
    logic                    resp_busy;
    logic                    resp_done;
    logic                    resp_drop;
    logic                    resp_err;

    modport slave (
        input  resp_req, resp_func, resp_ch, pwm_busy, pwm_valid, tx_busy,
        output tx_en, tx_data, resp_busy, resp_done, resp_drop, resp_err
    );

    modport master (
        output resp_req, resp_func, resp_ch, pwm_busy, pwm_valid, tx_busy,
        input  tx_en, tx_data, resp_busy, resp_done, resp_drop, resp_err
    );
endinterface

// File: rtl/uart_resp_framer.sv
// Snapshots channel status and streams an 8-byte status frame
// (sync, echo, status, sequence, checksum) to a byte-level UART transmitter.
module uart_resp_framer #(
    parameter int _NUM_CHANNELS = 3,
    parameter int _TX_TIMEOUT   = 16
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    uart_resp_framer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic [7:0] seq_q, seq_d;
    logic [7:0] func_q, func_d;
    logic [7:0] ch_q, ch_d;
    logic [7:0] busy_snap_q, busy_snap_d;
    logic [7:0] valid_snap_q, valid_snap_d;
    logic       pend_full_q, pend_full_d;
    logic [7:0] pend_func_q, pend_func_d;
    logic [7:0] pend_ch_q, pend_ch_d;
    logic       tx_en_q, tx_en_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       done_q, done_d;
    logic       drop_q, drop_d;
    logic       err_q, err_d;

    logic [7:0] pwm_busy_ext;
    logic [7:0] pwm_valid_ext;
    logic [7:0] checksum;
    logic       timeout_hit;

    always_comb begin
        pwm_busy_ext                      = '0;
        pwm_valid_ext                     = '0;
        pwm_busy_ext[_NUM_CHANNELS-1:0]  = bus.pwm_busy;
        pwm_valid_ext[_NUM_CHANNELS-1:0] = bus.pwm_valid;
    end

    // seq only moves when a frame completes, so its live value is already a stable snapshot.
    assign checksum = func_q + ch_q + busy_snap_q + valid_snap_q + seq_q;

    // The counter starts one cycle after tx_en, so this lands resp_err _TX_TIMEOUT cycles after it.
    assign timeout_hit = (to_cnt_q == 8'(_TX_TIMEOUT - 2));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.resp_req || pend_full_q) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_SEND;
            ST_SEND:    if (tx_en_q) state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (bus.tx_busy)      state_d = ST_WAIT_LO;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) state_d = (idx_q == 3'd7) ? ST_IDLE : ST_SEND;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        idx_d        = idx_q;
        to_cnt_d     = to_cnt_q;
        seq_d        = seq_q;
        func_d       = func_q;
        ch_d         = ch_q;
        busy_snap_d  = busy_snap_q;
        valid_snap_d = valid_snap_q;
        pend_full_d  = pend_full_q;
        pend_func_d  = pend_func_q;
        pend_ch_d    = pend_ch_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    func_d = pend_func_q;
                    ch_d   = pend_ch_q;
                end else if (bus.resp_req) begin
                    func_d = bus.resp_func;
                    ch_d   = bus.resp_ch;
                end
            end
            ST_LOAD: begin
                idx_d        = 3'd0;
                busy_snap_d  = pwm_busy_ext;
                valid_snap_d = pwm_valid_ext;
                tx_en_d      = !bus.tx_busy;
            end
            ST_SEND: begin
                // tx_en is looked ahead one cycle so it is high while SEND is current.
                if (tx_en_q) to_cnt_d = '0;
                else         tx_en_d  = !bus.tx_busy;
            end
            ST_WAIT_HI: begin
                to_cnt_d = to_cnt_q + 8'd1;
                err_d    = !bus.tx_busy && timeout_hit;
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (idx_q == 3'd7) begin
                        done_d = 1'b1;
                        seq_d  = seq_q + 8'd1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_en_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A pending request leaves the slot as IDLE starts serving it; a new request may refill it.
        if (state_q == ST_IDLE && pend_full_q) pend_full_d = 1'b0;
        if (bus.resp_req && (state_q != ST_IDLE || pend_full_q)) begin
            if (!pend_full_q || state_q == ST_IDLE) begin
                pend_full_d = 1'b1;
                pend_func_d = bus.resp_func;
                pend_ch_d   = bus.resp_ch;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (tx_en_d) begin
            case (idx_d)
                3'd0:    tx_data_d = 8'h55;
                3'd1:    tx_data_d = 8'hAA;
                3'd2:    tx_data_d = func_q;
                3'd3:    tx_data_d = ch_q;
                3'd4:    tx_data_d = busy_snap_q;
                3'd5:    tx_data_d = valid_snap_q;
                3'd6:    tx_data_d = seq_q;
                default: tx_data_d = checksum;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            to_cnt_q     <= '0;
            seq_q        <= '0;
            func_q       <= '0;
            ch_q         <= '0;
            busy_snap_q  <= '0;
            valid_snap_q <= '0;
            pend_full_q  <= 1'b0;
            pend_func_q  <= '0;
            pend_ch_q    <= '0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the values present before the edge.
            idx_q        <= idx_d;
            to_cnt_q     <= to_cnt_d;
            seq_q        <= seq_d;
            func_q       <= func_d;
            ch_q         <= ch_d;
            busy_snap_q  <= busy_snap_d;
            valid_snap_q <= valid_snap_d;
            pend_full_q  <= pend_full_d;
            pend_func_q  <= pend_func_d;
            pend_ch_q    <= pend_ch_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.resp_busy = (state_q != ST_IDLE) || pend_full_q;
    assign bus.resp_done = done_q;
    assign bus.resp_drop = drop_q;
    assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_uart_resp_framer.sv
// Directed bench for uart_resp_framer with a simple busy-for-N-cycles transmitter model.
module tb_uart_resp_framer;

    localparam int TIMEOUT = 16;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50M = ~clk_50M;

    uart_resp_framer_if #(.NUM_CHANNELS(3)) bus ();

    uart_resp_framer #(._NUM_CHANNELS(3), ._TX_TIMEOUT(TIMEOUT)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transmitter model: busy for tx_len cycles after each accepted tx_en, or never when dead.
    int busy_cnt = 0;
    int tx_len   = 10;
    bit tx_dead  = 1'b0;
    always @(posedge clk_50M) begin
        if (bus.tx_en && !tx_dead) busy_cnt <= tx_len;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Event monitor: everything it records only grows, tests work from baselines.
    logic [7:0] cap[$];
    logic       busy_at_done[$];
    int cyc = 0, tx_en_cnt = 0, done_cnt = 0, drop_cnt = 0, err_cnt = 0;
    int en_cyc = 0, err_cyc = 0;
    always @(posedge clk_50M) begin
        if (bus.tx_en) begin
            cap.push_back(bus.tx_data);
            tx_en_cnt++;
            en_cyc = cyc;
        end
        if (bus.resp_done) begin
            done_cnt++;
            busy_at_done.push_back(bus.resp_busy);
        end
        if (bus.resp_drop) drop_cnt++;
        if (bus.resp_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        cyc++;
    end

    function automatic logic [63:0] exp_frame(input logic [7:0] f, c, b, v, s);
        logic [7:0] sum;
        sum = f + c + b + v + s;
        return {8'h55, 8'hAA, f, c, b, v, s, sum};
    endfunction

    task automatic get_frame(input int base, output logic [63:0] f);
        f = 'x;
        if (cap.size() >= base + 8)
            for (int i = 0; i < 8; i++) f = {f[55:0], cap[base + i]};
    endtask

    task automatic send_req(input logic [7:0] f, input logic [7:0] c);
        @(negedge clk_50M);
        bus.resp_req  = 1'b1;
        bus.resp_func = f;
        bus.resp_ch   = c;
        @(negedge clk_50M);
        bus.resp_req  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_50M);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        total_cnt++; if (bus.tx_en !== 1'b0) $display("FAIL rst_tx_en: got %b want 0", bus.tx_en); else pass_cnt++;
        total_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); else pass_cnt++;
        total_cnt++; if (bus.resp_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.resp_busy); else pass_cnt++;
        total_cnt++; if (bus.resp_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.resp_done); else pass_cnt++;
        total_cnt++; if (bus.resp_drop !== 1'b0) $display("FAIL rst_drop: got %b want 0", bus.resp_drop); else pass_cnt++;
        total_cnt++; if (bus.resp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.resp_err); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk_50M);
    endtask

    task automatic test_single_frame();
        int b_cap, b_done;
        bit ok;
        logic [63:0] f;
        b_cap = cap.size();
        b_done = done_cnt;
        bus.pwm_busy  = 3'b101;
        bus.pwm_valid = 3'b010;
        send_req(8'h01, 8'h02);
        total_cnt++; if (bus.resp_busy !== 1'b1) $display("FAIL load_busy: got %b want 1", bus.resp_busy); else pass_cnt++;
        total_cnt++; if (bus.tx_en !== 1'b0) $display("FAIL load_tx_en: got %b want 0", bus.tx_en); else pass_cnt++;
        @(negedge clk_50M);
        total_cnt++; if (bus.tx_en !== 1'b1) $display("FAIL first_tx_en: got %b want 1", bus.tx_en); else pass_cnt++;
        total_cnt++; if (bus.tx_data !== 8'h55) $display("FAIL first_tx_data: got %h want 55", bus.tx_data); else pass_cnt++;
        wait_done(b_done + 1, 400, ok);
        total_cnt++; if (!ok) $display("FAIL single_done_timeout: got no resp_done want one"); else pass_cnt++;
        get_frame(b_cap, f);
        total_cnt++; if (f !== 64'h55AA01020502000A) $display("FAIL single_frame: got %h want 55aa01020502000a", f); else pass_cnt++;
        repeat (3) @(negedge clk_50M);
        total_cnt++; if (done_cnt !== b_done + 1) $display("FAIL single_done_cnt: got %0d want %0d", done_cnt - b_done, 1); else pass_cnt++;
        total_cnt++; if (busy_at_done[b_done] !== 1'b0) $display("FAIL single_busy_at_done: got %b want 0", busy_at_done[b_done]); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        int b_cap, b_done;
        bit ok;
        logic [63:0] f;
        b_cap = cap.size();
        b_done = done_cnt;
        send_req(8'h01, 8'h02);
        @(negedge clk_50M);
        bus.pwm_busy = 3'b111;
        wait_done(b_done + 1, 400, ok);
        total_cnt++; if (!ok) $display("FAIL snap_done_timeout: got no resp_done want one"); else pass_cnt++;
        get_frame(b_cap, f);
        total_cnt++; if (f !== 64'h55AA01020502010B) $display("FAIL snap_frame: got %h want 55aa01020502010b", f); else pass_cnt++;
        bus.pwm_busy = 3'b101;
    endtask

    task automatic test_back_to_back();
        int b_cap, b_done, b_drop, b_en;
        bit ok;
        logic [63:0] f;
        do_reset();
        b_cap = cap.size();
        b_done = done_cnt;
        b_drop = drop_cnt;
        b_en = tx_en_cnt;
        send_req(8'h01, 8'h02);
        repeat (5) @(negedge clk_50M);
        send_req(8'h02, 8'h03);
        repeat (5) @(negedge clk_50M);
        bus.resp_req  = 1'b1;
        bus.resp_func = 8'h07;
        bus.resp_ch   = 8'h07;
        @(negedge clk_50M);
        bus.resp_req  = 1'b0;
        total_cnt++; if (bus.resp_drop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", bus.resp_drop); else pass_cnt++;
        wait_done(b_done + 2, 800, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_done_timeout: got %0d frames want 2", done_cnt - b_done); else pass_cnt++;
        get_frame(b_cap, f);
        total_cnt++; if (f !== 64'h55AA01020502000A) $display("FAIL b2b_frame1: got %h want 55aa01020502000a", f); else pass_cnt++;
        get_frame(b_cap + 8, f);
        total_cnt++; if (f !== 64'h55AA02030502010D) $display("FAIL b2b_frame2: got %h want 55aa02030502010d", f); else pass_cnt++;
        total_cnt++; if (busy_at_done[b_done] !== 1'b1) $display("FAIL b2b_busy_held: got %b want 1", busy_at_done[b_done]); else pass_cnt++;
        total_cnt++; if (busy_at_done[b_done + 1] !== 1'b0) $display("FAIL b2b_busy_fall: got %b want 0", busy_at_done[b_done + 1]); else pass_cnt++;
        repeat (100) @(negedge clk_50M);
        total_cnt++; if (tx_en_cnt - b_en !== 16) $display("FAIL b2b_no_third: got %0d bytes want 16", tx_en_cnt - b_en); else pass_cnt++;
        total_cnt++; if (drop_cnt - b_drop !== 1) $display("FAIL b2b_drop_cnt: got %0d want 1", drop_cnt - b_drop); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int b_cap, b_done, b_err, b_en;
        bit ok;
        logic [63:0] f;
        b_done = done_cnt;
        b_err = err_cnt;
        b_en = tx_en_cnt;
        tx_dead = 1'b1;
        send_req(8'h05, 8'h06);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50M);
            if (err_cnt != b_err) break;
        end
        repeat (2) @(negedge clk_50M);
        total_cnt++; if (err_cnt - b_err !== 1) $display("FAIL to_err_cnt: got %0d want 1", err_cnt - b_err); else pass_cnt++;
        total_cnt++; if (err_cyc - en_cyc !== TIMEOUT) $display("FAIL to_latency: got %0d want %0d", err_cyc - en_cyc, TIMEOUT); else pass_cnt++;
        total_cnt++; if (tx_en_cnt - b_en !== 1) $display("FAIL to_tx_en_cnt: got %0d want 1", tx_en_cnt - b_en); else pass_cnt++;
        total_cnt++; if (done_cnt !== b_done) $display("FAIL to_no_done: got %0d want 0", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (bus.resp_busy !== 1'b0) $display("FAIL to_idle: got busy %b want 0", bus.resp_busy); else pass_cnt++;
        tx_dead = 1'b0;
        b_cap = cap.size();
        send_req(8'h01, 8'h02);
        wait_done(b_done + 1, 400, ok);
        total_cnt++; if (!ok) $display("FAIL to_next_timeout: got no resp_done want one"); else pass_cnt++;
        get_frame(b_cap, f);
        total_cnt++; if (f !== 64'h55AA01020502020C) $display("FAIL to_seq_kept: got %h want 55aa01020502020c", f); else pass_cnt++;
    endtask

    task automatic test_seq_wrap();
        int b_done, base;
        bit ok, all_ok;
        logic [63:0] f256, f257;
        do_reset();
        tx_len = 1;
        bus.pwm_busy  = '0;
        bus.pwm_valid = '0;
        b_done = done_cnt;
        all_ok = 1'b1;
        f256 = 'x;
        f257 = 'x;
        for (int k = 1; k <= 257; k++) begin
            base = cap.size();
            send_req(8'h00, 8'h00);
            wait_done(b_done + k, 200, ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
            if (k == 256) get_frame(base, f256);
            if (k == 257) get_frame(base, f257);
        end
        total_cnt++; if (!all_ok) $display("FAIL wrap_progress: got %0d frames want 257", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (f256 !== exp_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF)) $display("FAIL wrap_frame256: got %h want 55aa00000000ffff", f256); else pass_cnt++;
        total_cnt++; if (f257 !== exp_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00)) $display("FAIL wrap_frame257: got %h want 55aa000000000000", f257); else pass_cnt++;
        tx_len = 10;
    endtask

    task automatic test_reset_mid_frame();
        int n_en, b_cap, b_done;
        bit ok;
        logic [63:0] f;
        bus.pwm_busy  = 3'b101;
        bus.pwm_valid = 3'b010;
        n_en = 0;
        send_req(8'h01, 8'h02);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50M);
            if (bus.tx_en === 1'b1) n_en++;
            if (n_en == 4) break;
        end
        total_cnt++; if (n_en != 4) $display("FAIL mid_reach_b3: got %0d bytes want 4", n_en); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.tx_en !== 1'b0) $display("FAIL mid_tx_en: got %b want 0", bus.tx_en); else pass_cnt++;
        total_cnt++; if (bus.resp_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.resp_busy); else pass_cnt++;
        total_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL mid_tx_data: got %h want 00", bus.tx_data); else pass_cnt++;
        @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (12) @(negedge clk_50M);
        b_cap = cap.size();
        b_done = done_cnt;
        send_req(8'h01, 8'h02);
        wait_done(b_done + 1, 400, ok);
        total_cnt++; if (!ok) $display("FAIL mid_restart_timeout: got no resp_done want one"); else pass_cnt++;
        get_frame(b_cap, f);
        total_cnt++; if (f !== 64'h55AA01020502000A) $display("FAIL mid_restart_frame: got %h want 55aa01020502000a", f); else pass_cnt++;
    endtask

    initial begin
        bus.resp_req  = 1'b0;
        bus.resp_func = '0;
        bus.resp_ch   = '0;
        bus.pwm_busy  = '0;
        bus.pwm_valid = '0;
        test_reset();
        test_single_frame();
        test_snapshot();
        test_back_to_back();
        test_timeout();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
